prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer_pkg.sv | 15 +
 rtl/prog_timer_presc.sv | 29 ++
 rtl/prog_timer.sv | 113 +++++++++++
 tb/tb_prog_timer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// rtl/prog_timer_pkg.sv - state encodings and direction/mode constants for prog_timer
package prog_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DN       = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/prog_timer_presc.sv
// rtl/prog_timer_presc.sv - tick prescaler, counts 0..presc and ticks at wrap
module prog_timer_presc #(
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] presc_i,
  output logic             tick_o
);

  localparam logic [PRE_W-1:0] ONE = PRE_W'(1);

  logic [PRE_W-1:0] pcnt_q;

  assign tick_o = en_i && !clr_i && (pcnt_q == presc_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else if (clr_i || !en_i || tick_o) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + ONE;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - programmable up/down timer; optional prescaler under PROG_TIMER_PRESCALER_EN
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int N     = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [N-1:0]     tc_i,
`ifdef PROG_TIMER_PRESCALER_EN
  input  logic [PRE_W-1:0] presc_i,
`endif
  output logic [N-1:0]     cnt_o,
  output logic             flag_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_n;
  logic         dir_q, mode_q;
  logic [N-1:0] tc_q;
  logic [N-1:0] cnt_n, start_val, end_val;
  logic         flag_n, tick;

  assign start_val = (dir_q == DIR_DN) ? tc_q : '0;
  assign end_val   = (dir_q == DIR_DN) ? '0   : tc_q;

`ifdef PROG_TIMER_PRESCALER_EN
  logic [PRE_W-1:0] presc_q;

  prog_timer_presc #(.PRE_W(PRE_W)) u_presc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (start_i | stop_i),
    .en_i    (state_q == RUN),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (start_i && !stop_i) begin
      presc_q <= presc_i;
    end
  end
`else
  assign tick = (state_q == RUN);

  // PRE_W only sizes the prescaler; reference it so the default build elaborates cleanly
  if (PRE_W < 1) begin : g_pre_w_invalid
  end
`endif

  // stop beats start, start beats a terminal tick
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_o;
    flag_n  = 1'b0;
    if (stop_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (start_i) begin
      state_n = RUN;
      cnt_n   = (dir_i == DIR_DN) ? tc_i : '0;
    end else if (state_q == RUN && tick) begin
      if (cnt_o == end_val) begin
        flag_n = 1'b1;
        if (mode_q == MODE_RELOAD) begin
          cnt_n = start_val;
        end else begin
          state_n = DONE;
        end
      end else if (dir_q == DIR_DN) begin
        cnt_n = cnt_o - ONE;
      end else begin
        cnt_n = cnt_o + ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_o   <= '0;
      flag_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      tc_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_o   <= cnt_n;
      flag_o  <= flag_n;
      busy_o  <= (state_n == RUN);
      done_o  <= (state_n == DONE);
      if (start_i && !stop_i) begin
        dir_q  <= dir_i;
        mode_q <= mode_i;
        tc_q   <= tc_i;
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// tb/tb_prog_timer.sv - directed self-checking bench for prog_timer (N=4)
module tb_prog_timer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       dir_i = 1'b0;
  logic       mode_i = 1'b0;
  logic [3:0] tc_i = 4'd0;
`ifdef PROG_TIMER_PRESCALER_EN
  logic [7:0] presc_i = 8'd0;
`endif
  logic [3:0] cnt_o;
  logic       flag_o, busy_o, done_o;

  int passed = 0;
  int total  = 0;

  prog_timer #(.N(4), .PRE_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .dir_i   (dir_i),
    .mode_i  (mode_i),
    .tc_i    (tc_i),
`ifdef PROG_TIMER_PRESCALER_EN
    .presc_i (presc_i),
`endif
    .cnt_o   (cnt_o),
    .flag_o  (flag_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic d, input logic m, input logic [3:0] tc);
    dir_i = d; mode_i = m; tc_i = tc; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (cnt_o !== 4'd0) $display("FAIL reset_cnt got %0d want 0", cnt_o); else passed++;
    total++; if (flag_o !== 1'b0) $display("FAIL reset_flag got %0b want 0", flag_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL reset_done got %0b want 0", done_o); else passed++;
    rst_i = 1'b0;
    step(); step();
    total++; if (busy_o !== 1'b0 || cnt_o !== 4'd0) $display("FAIL idle_after_reset busy=%0b cnt=%0d want busy=0 cnt=0", busy_o, cnt_o); else passed++;
  endtask

  task automatic test_up_reload();
    do_start(1'b0, 1'b1, 4'd9);
    total++; if (cnt_o !== 4'd0 || busy_o !== 1'b1) $display("FAIL up_start cnt=%0d busy=%0b want cnt=0 busy=1", cnt_o, busy_o); else passed++;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++; if (cnt_o !== 4'(k % 10)) $display("FAIL up_cnt k=%0d got %0d want %0d", k, cnt_o, k % 10); else passed++;
      total++; if (flag_o !== (k % 10 == 0)) $display("FAIL up_flag k=%0d got %0b want %0b", k, flag_o, (k % 10 == 0)); else passed++;
      total++; if (busy_o !== 1'b1) $display("FAIL up_busy k=%0d got %0b want 1", k, busy_o); else passed++;
    end
  endtask

  task automatic test_down_oneshot();
    do_start(1'b1, 1'b0, 4'd5);
    total++; if (cnt_o !== 4'd5) $display("FAIL dn_start got %0d want 5", cnt_o); else passed++;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (cnt_o !== 4'(5 - k) || flag_o !== 1'b0) $display("FAIL dn_cnt k=%0d cnt=%0d flag=%0b want cnt=%0d flag=0", k, cnt_o, flag_o, 5 - k); else passed++;
    end
    step();
    total++; if (flag_o !== 1'b1 || done_o !== 1'b1 || busy_o !== 1'b0 || cnt_o !== 4'd0) $display("FAIL dn_term flag=%0b done=%0b busy=%0b cnt=%0d want 1 1 0 0", flag_o, done_o, busy_o, cnt_o); else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (flag_o !== 1'b0 || done_o !== 1'b1 || cnt_o !== 4'd0) $display("FAIL dn_hold k=%0d flag=%0b done=%0b cnt=%0d want 0 1 0", k, flag_o, done_o, cnt_o); else passed++;
    end
    do_start(1'b1, 1'b0, 4'd5);
    total++; if (cnt_o !== 4'd5 || busy_o !== 1'b1 || done_o !== 1'b0) $display("FAIL dn_restart cnt=%0d busy=%0b done=%0b want 5 1 0", cnt_o, busy_o, done_o); else passed++;
  endtask

  task automatic test_tc_zero();
    do_start(1'b0, 1'b1, 4'd0);
    total++; if (flag_o !== 1'b0 || cnt_o !== 4'd0) $display("FAIL tc0_start flag=%0b cnt=%0d want 0 0", flag_o, cnt_o); else passed++;
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (flag_o !== 1'b1 || cnt_o !== 4'd0) $display("FAIL tc0_tick k=%0d flag=%0b cnt=%0d want 1 0", k, flag_o, cnt_o); else passed++;
    end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    total++; if (flag_o !== 1'b0 || busy_o !== 1'b0 || cnt_o !== 4'd0) $display("FAIL tc0_stop flag=%0b busy=%0b cnt=%0d want 0 0 0", flag_o, busy_o, cnt_o); else passed++;
  endtask

  task automatic test_stop_start_terminal();
    do_start(1'b0, 1'b1, 4'd2);
    step(); step();
    total++; if (cnt_o !== 4'd2) $display("FAIL ss_pre got %0d want 2", cnt_o); else passed++;
    start_i = 1'b1; stop_i = 1'b1;
    step();
    start_i = 1'b0; stop_i = 1'b0;
    total++; if (busy_o !== 1'b0 || cnt_o !== 4'd0 || flag_o !== 1'b0 || done_o !== 1'b0) $display("FAIL ss_prio busy=%0b cnt=%0d flag=%0b done=%0b want 0 0 0 0", busy_o, cnt_o, flag_o, done_o); else passed++;
    step();
    total++; if (busy_o !== 1'b0 || flag_o !== 1'b0) $display("FAIL ss_idle busy=%0b flag=%0b want 0 0", busy_o, flag_o); else passed++;
  endtask

  task automatic test_shadow();
    do_start(1'b0, 1'b1, 4'd4);
    tc_i = 4'd1; dir_i = 1'b1; mode_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++; if (cnt_o !== 4'(k % 5) || flag_o !== (k % 5 == 0) || busy_o !== 1'b1) $display("FAIL shadow k=%0d cnt=%0d flag=%0b busy=%0b want %0d %0b 1", k, cnt_o, flag_o, busy_o, k % 5, (k % 5 == 0)); else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_start(1'b0, 1'b1, 4'd9);
    step(); step(); step();
    total++; if (cnt_o !== 4'd3) $display("FAIL ar_pre got %0d want 3", cnt_o); else passed++;
    rst_i = 1'b1;
    #1;
    total++; if (cnt_o !== 4'd0 || flag_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) $display("FAIL ar_async cnt=%0d flag=%0b busy=%0b done=%0b want all 0", cnt_o, flag_o, busy_o, done_o); else passed++;
    step();
    rst_i = 1'b0;
    step(); step();
    total++; if (busy_o !== 1'b0 || cnt_o !== 4'd0 || flag_o !== 1'b0) $display("FAIL ar_idle busy=%0b cnt=%0d flag=%0b want 0 0 0", busy_o, cnt_o, flag_o); else passed++;
  endtask

`ifdef PROG_TIMER_PRESCALER_EN
  task automatic test_prescaler();
    presc_i = 8'd3;
    do_start(1'b0, 1'b1, 4'd2);
    presc_i = 8'd0;
    for (int k = 1; k <= 14; k++) begin
      step();
      total++; if (cnt_o !== 4'((k / 4) % 3) || flag_o !== (k == 12)) $display("FAIL presc k=%0d cnt=%0d flag=%0b want %0d %0b", k, cnt_o, flag_o, (k / 4) % 3, (k == 12)); else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_reload();
    test_down_oneshot();
    test_tc_zero();
    test_stop_start_terminal();
    test_shadow();
    test_async_reset();
`ifdef PROG_TIMER_PRESCALER_EN
    test_prescaler();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
